// File: rtl/debug_pkg.sv
// Shared constants and state encoding for the debug command decoder.
package debug_pkg;

  localparam logic [7:0] OP_SIGNAL  = 8'h01;
  localparam logic [7:0] OP_OK      = 8'h02;
  localparam logic [7:0] OP_PING    = 8'h03;
  localparam logic [7:0] OP_PAUSE   = 8'h04;
  localparam logic [7:0] OP_RESUME  = 8'h05;
  localparam logic [7:0] OP_NEXT    = 8'h06;
  localparam logic [7:0] OP_PROGRAM = 8'h07;
  localparam logic [7:0] OP_NONE    = 8'hFF;

  localparam logic [31:0] BP_DISABLED = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BP    = 2'd1,
    ST_PLEN  = 2'd2,
    ST_PWORD = 2'd3
  } state_t;

endpackage

// File: rtl/debug_cmd_decoder_if.sv
// Byte stream from UART RX and the OK-byte handshake towards UART TX.
interface debug_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       ack_valid;
  logic [7:0] ack_data;
  logic       ack_ready;

  // master: UART side; slave: the decoder
  modport master (output rx_data, rx_valid, ack_ready, input ack_valid, ack_data);
  modport slave  (input rx_data, rx_valid, ack_ready, output ack_valid, ack_data);
endinterface

// File: rtl/debug_byte_assembler.sv
// Collects little-endian bytes into a 32-bit word; word_next carries the
// completed word in the same cycle word_done is raised.
module debug_byte_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  input  logic [1:0]  last_idx,
  output logic [31:0] word_next,
  output logic        word_done
);

  logic [31:0] word;
  logic [1:0]  idx;

  always_comb begin
    word_next = word;
    word_next[{idx, 3'b000} +: 8] = byte_in;
    word_done = byte_valid && (idx == last_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      idx  <= '0;
    end else if (clr) begin
      word <= '0;
      idx  <= '0;
    end else if (byte_valid) begin
      if (word_done) begin
        word <= '0;
        idx  <= '0;
      end else begin
        word <= word_next;
        idx  <= idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/debug_cmd_decoder.sv
// Host debug command decoder: pause/resume/step/ping/program-load.
// Optional payload timeout enabled by defining DEBUG_TIMEOUT_EN.
module debug_cmd_decoder
  import debug_pkg::*;
#(
  parameter int PROG_ADDR_W    = 14,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  debug_cmd_decoder_if.slave     bus,
  output logic                   cpu_pause,
  output logic                   step,
  output logic [31:0]            bp_addr,
  output logic                   prog_we,
  output logic [PROG_ADDR_W-1:0] prog_addr,
  output logic [31:0]            prog_data,
  output logic                   prog_busy,
  output logic                   cpu_rst_req,
  output logic                   abort
);

  state_t      state;
  logic [15:0] word_cnt;
  logic [15:0] word_total;
  logic        ack_valid;
  logic        tmo_hit;
  logic [31:0] word_next;
  logic        word_done;

  wire rx_valid = bus.rx_valid;
  wire in_payload = (state != ST_IDLE);

  assign bus.ack_valid = ack_valid;
  assign bus.ack_data  = OP_OK;

  debug_byte_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (tmo_hit),
    .byte_valid (rx_valid && in_payload),
    .byte_in    (bus.rx_data),
    .last_idx   ((state == ST_PLEN) ? 2'd1 : 2'd3),
    .word_next  (word_next),
    .word_done  (word_done)
  );

`ifdef DEBUG_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // An arriving byte always beats an expiring counter.
  assign tmo_hit = in_payload && !rx_valid && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      abort   <= 1'b0;
    end else begin
      abort <= tmo_hit;
      if (!in_payload || rx_valid || tmo_hit) tmo_cnt <= '0;
      else                                    tmo_cnt <= tmo_cnt + 32'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign abort   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cpu_pause   <= 1'b0;
      step        <= 1'b0;
      bp_addr     <= BP_DISABLED;
      prog_we     <= 1'b0;
      prog_addr   <= '0;
      prog_data   <= '0;
      prog_busy   <= 1'b0;
      cpu_rst_req <= 1'b0;
      ack_valid   <= 1'b0;
      word_cnt    <= '0;
      word_total  <= '0;
    end else begin
      step        <= 1'b0;
      prog_we     <= 1'b0;
      cpu_rst_req <= 1'b0;
      if (ack_valid && bus.ack_ready) ack_valid <= 1'b0;

      if (tmo_hit) begin
        state     <= ST_IDLE;
        prog_busy <= 1'b0;
      end else if (rx_valid) begin
        unique case (state)
          ST_IDLE: begin
            unique case (bus.rx_data)
              OP_PING:  ack_valid <= 1'b1;
              OP_PAUSE: cpu_pause <= 1'b1;
              OP_NEXT:  step      <= cpu_pause;
              OP_RESUME: state    <= ST_BP;
              OP_PROGRAM: begin
                cpu_pause <= 1'b1;
                prog_busy <= 1'b1;
                word_cnt  <= '0;
                state     <= ST_PLEN;
              end
              default: ;
            endcase
          end
          ST_BP: if (word_done) begin
            bp_addr <= word_next;
            if (!prog_busy) cpu_pause <= 1'b0;
            state   <= ST_IDLE;
          end
          ST_PLEN: if (word_done) begin
            if (word_next[15:0] == 16'd0) begin
              prog_busy   <= 1'b0;
              cpu_rst_req <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              word_total <= word_next[15:0];
              state      <= ST_PWORD;
            end
          end
          ST_PWORD: if (word_done) begin
            prog_we   <= 1'b1;
            prog_addr <= PROG_ADDR_W'(word_cnt);
            prog_data <= word_next;
            word_cnt  <= word_cnt + 16'd1;
            if (word_cnt == word_total - 16'd1) begin
              prog_busy   <= 1'b0;
              cpu_rst_req <= 1'b1;
              state       <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_debug_cmd_decoder.sv
// Directed table-driven bench for debug_cmd_decoder plus ack, timeout and reset sequences.
module tb_debug_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_pause, step, prog_we, prog_busy, cpu_rst_req, abort;
  logic [31:0] bp_addr, prog_data;
  logic [13:0] prog_addr;

  int n_checks = 0;
  int n_fail   = 0;

  debug_cmd_decoder_if bus();

  debug_cmd_decoder #(.PROG_ADDR_W(14), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .cpu_pause(cpu_pause), .step(step), .bp_addr(bp_addr),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_busy(prog_busy), .cpu_rst_req(cpu_rst_req), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        v;
    logic        pause;
    logic        step;
    logic        we;
    logic [13:0] addr;
    logic [31:0] data;
    logic        busy;
    logic        rstreq;
    logic [31:0] bp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] d, input logic v, input logic pause, input logic stp,
                     input logic we, input logic [13:0] addr, input logic [31:0] data,
                     input logic busy, input logic rstreq, input logic [31:0] bp);
    vec_t t;
    t.d = d; t.v = v; t.pause = pause; t.step = stp; t.we = we; t.addr = addr;
    t.data = data; t.busy = busy; t.rstreq = rstreq; t.bp = bp;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] bp_saved;
    int hs;
    int we_seen;
    bit stayed;
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.ack_ready = 1'b1;

    // d, v, pause, step, we, addr, data, busy, rstreq, bp
    add(8'h00, 0, 0, 0, 0, 0, 32'h0,         0, 0, 32'hFFFF_FFFF); // reset state
    add(8'h06, 1, 0, 0, 0, 0, 32'h0,         0, 0, 32'hFFFF_FFFF); // NEXT while running
    add(8'h55, 1, 0, 0, 0, 0, 32'h0,         0, 0, 32'hFFFF_FFFF); // unknown byte ignored
    add(8'h04, 1, 1, 0, 0, 0, 32'h0,         0, 0, 32'hFFFF_FFFF); // PAUSE
    add(8'h06, 1, 1, 1, 0, 0, 32'h0,         0, 0, 32'hFFFF_FFFF); // NEXT -> step
    add(8'h00, 0, 1, 0, 0, 0, 32'h0,         0, 0, 32'hFFFF_FFFF);
    add(8'h05, 1, 1, 0, 0, 0, 32'h0,         0, 0, 32'hFFFF_FFFF); // RESUME
    add(8'h0C, 1, 1, 0, 0, 0, 32'h0,         0, 0, 32'hFFFF_FFFF);
    add(8'h00, 1, 1, 0, 0, 0, 32'h0,         0, 0, 32'hFFFF_FFFF);
    add(8'h00, 1, 1, 0, 0, 0, 32'h0,         0, 0, 32'hFFFF_FFFF);
    add(8'h00, 1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0000_000C);
    add(8'h07, 1, 1, 0, 0, 0, 32'h0,         1, 0, 32'h0000_000C); // PROGRAM
    add(8'h02, 1, 1, 0, 0, 0, 32'h0,         1, 0, 32'h0000_000C);
    add(8'h00, 1, 1, 0, 0, 0, 32'h0,         1, 0, 32'h0000_000C);
    add(8'h01, 1, 1, 0, 0, 0, 32'h0,         1, 0, 32'h0000_000C);
    add(8'h01, 1, 1, 0, 0, 0, 32'h0,         1, 0, 32'h0000_000C);
    add(8'h01, 1, 1, 0, 0, 0, 32'h0,         1, 0, 32'h0000_000C);
    add(8'h01, 1, 1, 0, 1, 0, 32'h0101_0101, 1, 0, 32'h0000_000C);
    add(8'hAA, 1, 1, 0, 0, 0, 32'h0101_0101, 1, 0, 32'h0000_000C);
    add(8'hBB, 1, 1, 0, 0, 0, 32'h0101_0101, 1, 0, 32'h0000_000C);
    add(8'hCC, 1, 1, 0, 0, 0, 32'h0101_0101, 1, 0, 32'h0000_000C);
    add(8'hDD, 1, 1, 0, 1, 1, 32'hDDCC_BBAA, 0, 1, 32'h0000_000C);
    add(8'h00, 0, 1, 0, 0, 1, 32'hDDCC_BBAA, 0, 0, 32'h0000_000C);
    add(8'h07, 1, 1, 0, 0, 1, 32'hDDCC_BBAA, 1, 0, 32'h0000_000C); // PROGRAM N=0
    add(8'h00, 1, 1, 0, 0, 1, 32'hDDCC_BBAA, 1, 0, 32'h0000_000C);
    add(8'h00, 1, 1, 0, 0, 1, 32'hDDCC_BBAA, 0, 1, 32'h0000_000C);
    add(8'h05, 1, 1, 0, 0, 1, 32'hDDCC_BBAA, 0, 0, 32'h0000_000C); // RESUME, opcodes as data
    add(8'h07, 1, 1, 0, 0, 1, 32'hDDCC_BBAA, 0, 0, 32'h0000_000C);
    add(8'h03, 1, 1, 0, 0, 1, 32'hDDCC_BBAA, 0, 0, 32'h0000_000C);
    add(8'h04, 1, 1, 0, 0, 1, 32'hDDCC_BBAA, 0, 0, 32'h0000_000C);
    add(8'h05, 1, 0, 0, 0, 1, 32'hDDCC_BBAA, 0, 0, 32'h0504_0307);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.rx_data  = vecs[i].d;
      bus.rx_valid = vecs[i].v;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d pause", i), 64'(cpu_pause), 64'(vecs[i].pause));
      check($sformatf("vec%0d step", i), 64'(step), 64'(vecs[i].step));
      check($sformatf("vec%0d prog_we", i), 64'(prog_we), 64'(vecs[i].we));
      check($sformatf("vec%0d prog_addr/data", i), {18'd0, prog_addr, prog_data},
            {18'd0, vecs[i].addr, vecs[i].data});
      check($sformatf("vec%0d busy/rst_req/ack", i), {61'd0, prog_busy, cpu_rst_req, bus.ack_valid},
            {61'd0, vecs[i].busy, vecs[i].rstreq, 1'b0});
      check($sformatf("vec%0d bp_addr", i), 64'(bp_addr), 64'(vecs[i].bp));
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;

    // PING held off for 20 cycles, second PING coalesced.
    bus.ack_ready = 1'b0;
    send(8'h03);
    check("ping ack_valid", 64'(bus.ack_valid), 64'd1);
    check("ack_data", 64'(bus.ack_data), 64'h02);
    stayed = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.ack_valid !== 1'b1) stayed = 1'b0;
    end
    check("ack held while not ready", 64'(stayed), 64'd1);
    send(8'h03);
    bus.ack_ready = 1'b1;
    hs = 0;
    repeat (6) begin
      if (bus.ack_valid && bus.ack_ready) hs++;
      @(negedge clk);
    end
    check("ack handshakes", 64'(hs), 64'd1);
    check("ack cleared", 64'(bus.ack_valid), 64'd0);

`ifdef DEBUG_TIMEOUT_EN
    bp_saved = bp_addr;
    send(8'h05);
    send(8'h11);
    bus.rx_data = 8'h22; bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    hs = 0;
    while (!abort && hs < 80) begin
      @(posedge clk);
      #1;
      hs++;
    end
    check("abort cycle", 64'(hs), 64'd50);
    @(posedge clk);
    #1;
    check("abort one pulse", 64'(abort), 64'd0);
    check("bp after timeout", 64'(bp_addr), 64'(bp_saved));
    send(8'h03);
    check("ping after timeout", 64'(bus.ack_valid), 64'd1);
    repeat (2) @(negedge clk);
`else
    bp_saved = bp_addr;
    check("abort tied low", 64'(abort), 64'd0);
    check("bp unchanged", 64'(bp_addr), 64'(bp_saved));
`endif

    // Reset in the middle of a PWORD field.
    send(8'h07);
    send(8'h01);
    send(8'h00);
    send(8'hAA);
    send(8'hBB);
    check("busy before reset", 64'(prog_busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset mid-payload outputs",
          {55'd0, cpu_pause, step, prog_we, prog_busy, cpu_rst_req, bus.ack_valid, abort, |prog_addr, |prog_data},
          64'd0);
    check("reset mid-payload bp", 64'(bp_addr), 64'hFFFF_FFFF);
    @(negedge clk);
    rst_n = 1'b1;
    we_seen = 0;
    fork
      begin
        send(8'hCC);
        send(8'hDD);
        repeat (3) @(negedge clk);
      end
      begin
        repeat (8) begin
          @(posedge clk);
          #1;
          if (prog_we) we_seen++;
        end
      end
    join
    check("no prog_we after reset", 64'(we_seen), 64'd0);
    check("busy after reset", 64'(prog_busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
